tlu_handshake_controller: RTL
=============================

Name: tlu_handshake_controller

Overview:
- Top-level sequencer for the TLU trigger interface.
- Detects accepted TLU triggers, drives the TLU BUSY handshake and starts the serial-to-parallel trigger-data deserializer via TLU_RECEIVE_DATA_FLAG.
- Waits for that deserializer's TLU_DATA_RECEIVED_FLAG, then releases BUSY and re-arms.
- Keeps an internal trigger counter and flags handshake timeouts for the readout registers.

Parameters:
TIMEOUT_WIDTH, 16, width of TIMEOUT_CYCLES and the internal timeout counter
COUNTER_WIDTH, 32, width of TRIGGER_COUNTER

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
TRIGGER_ENABLE  in  1  level; 0 blocks new acceptances
TRIGGER_MODE  in  2  0=simple, 1=handshake no data, 2=handshake with data, 3=disabled
TLU_TRIGGER  in  1  TLU trigger, already synchronized to CLK
TLU_BUSY  out  1  BUSY line to TLU
TLU_RECEIVE_DATA_FLAG  out  1  1-cycle start pulse to deserializer
TLU_DATA_RECEIVED_FLAG  in  1  1-cycle done pulse from deserializer
TRIGGER_ACCEPTED_FLAG  out  1  1-cycle pulse per completed trigger
TRIGGER_COUNTER  out  COUNTER_WIDTH  accepted-trigger count
TRIGGER_COUNTER_RESET  in  1  synchronous clear of TRIGGER_COUNTER
TIMEOUT_CYCLES  in  TIMEOUT_WIDTH  handshake timeout; 0 = timeout disabled
TIMEOUT_ERROR  out  1  sticky timeout flag
TIMEOUT_ERROR_CLEAR  in  1  synchronous clear of TIMEOUT_ERROR

Behaviour:
- Reset values: all outputs 0, state IDLE, edge register 0, latched mode 0, timeout counter 0.
- All outputs are registered.
- Edge detect: trig_prev <= TLU_TRIGGER. An edge is TLU_TRIGGER=1 with trig_prev=0.
- Acceptance: in IDLE only, requires edge, TRIGGER_ENABLE=1 and TRIGGER_MODE!=3.
  - TRIGGER_MODE is latched on acceptance; mode changes mid-handshake are ignored.
  - Edges outside IDLE are ignored and not counted.
- States:
  - IDLE: on acceptance go to WAIT_LOW for mode 0/1, or to REQ_DATA for mode 2.
  - REQ_DATA: TLU_RECEIVE_DATA_FLAG=1 for exactly this cycle; go to WAIT_DATA.
  - WAIT_DATA: on TLU_DATA_RECEIVED_FLAG=1 go to WAIT_LOW.
  - WAIT_LOW: when TLU_TRIGGER=0 go to IDLE.
- Latency (edge sampled at clock edge k):
  - Modes 1/2: TLU_BUSY=1 from k+1, through REQ_DATA/WAIT_DATA/WAIT_LOW; returns to 0 in the cycle after TLU_TRIGGER is sampled low in WAIT_LOW. Mode 0 never asserts BUSY.
  - TRIGGER_ACCEPTED_FLAG pulses at k+1 for modes 0/1.
  - For mode 2 it pulses in the cycle after TLU_DATA_RECEIVED_FLAG is sampled high.
  - TRIGGER_COUNTER increments together with TRIGGER_ACCEPTED_FLAG and wraps from all-ones to 0.
- TRIGGER_COUNTER_RESET coincident with an increment: counter becomes 0 (clear wins).
- Timeout:
  - Counter clears on entering WAIT_DATA or WAIT_LOW and increments each cycle in those states, saturating.
  - If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: set TIMEOUT_ERROR, go to IDLE, drop BUSY next cycle.
  - Timeout in WAIT_DATA gives no TRIGGER_ACCEPTED_FLAG and no count.
  - The trigger must go low and rise again before it can be re-accepted (edge detect).
- TIMEOUT_ERROR_CLEAR coincident with a set: set wins.
- TRIGGER_ENABLE falling mid-handshake: the current handshake completes normally.
- TLU_DATA_RECEIVED_FLAG outside WAIT_DATA: ignored.
- RESET mid-operation: immediate return to IDLE with all outputs 0; BUSY drops asynchronously.

Optional Feature:
- Macro: TLU_HANDSHAKE_VETO_EN.
- When defined:
  - Adds input VETO (1) and output VETOED_COUNTER (16, saturating at 0xFFFF, cleared by TRIGGER_COUNTER_RESET).
  - An edge in IDLE with VETO=1 is not accepted and increments VETOED_COUNTER.
  - In modes 1/2 a vetoed edge still raises TLU_BUSY and goes to WAIT_LOW without pulsing TRIGGER_ACCEPTED_FLAG. This makes the TLU drop the trigger.
- When undefined: ports absent; behaviour identical to VETO=0.

Test Plan:
- Mode 0, three trigger pulses each 4 cycles high -> TLU_BUSY stays 0; three TRIGGER_ACCEPTED_FLAG pulses; TRIGGER_COUNTER=3.
- Mode 2:
  - Stimulus: edge at cycle 10; TLU_DATA_RECEIVED_FLAG at cycle 50; trigger low at cycle 55.
  - Response: BUSY=1 from cycle 11; RECEIVE_DATA_FLAG only in cycle 11; ACCEPTED_FLAG in cycle 51; BUSY=0 from cycle 56; counter=1.
- Mode 1, TIMEOUT_CYCLES=20, trigger held high -> TIMEOUT_ERROR=1, BUSY drops after 20 cycles in WAIT_LOW. No re-accept until the trigger falls and rises again. TIMEOUT_ERROR_CLEAR returns it to 0.
- Mode 2, second trigger edge while in WAIT_DATA -> ignored: one RECEIVE_DATA_FLAG pulse, counter increments by 1 only.
- TRIGGER_COUNTER=0xFFFFFFFF plus one trigger -> 0. TRIGGER_COUNTER_RESET in the same cycle as an increment -> 0.
- RESET asserted in WAIT_DATA -> BUSY=0 immediately, all outputs 0. After release a new edge is handled normally and the counter restarts at 1.

Source files
------------

// File: rtl/tlu_handshake_controller.sv
// tlu_handshake_controller: TLU trigger/BUSY handshake sequencer.
// Accepts TLU trigger edges, drives BUSY, requests trigger data from the
// deserializer, counts completed triggers and flags handshake timeouts.
// Optional feature macro: TLU_HANDSHAKE_VETO_EN (adds VETO / VETOED_COUNTER).
module tlu_handshake_controller #(
  parameter int TIMEOUT_WIDTH = 16,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     TRIGGER_ENABLE,
  input  logic [1:0]               TRIGGER_MODE,
  input  logic                     TLU_TRIGGER,
  output logic                     TLU_BUSY,
  output logic                     TLU_RECEIVE_DATA_FLAG,
  input  logic                     TLU_DATA_RECEIVED_FLAG,
  output logic                     TRIGGER_ACCEPTED_FLAG,
  output logic [COUNTER_WIDTH-1:0] TRIGGER_COUNTER,
  input  logic                     TRIGGER_COUNTER_RESET,
  input  logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES,
  output logic                     TIMEOUT_ERROR,
  input  logic                     TIMEOUT_ERROR_CLEAR
`ifdef TLU_HANDSHAKE_VETO_EN
  ,
  input  logic                     VETO,
  output logic [15:0]              VETOED_COUNTER
`endif
);

  typedef enum logic [1:0] {IDLE, REQ_DATA, WAIT_DATA, WAIT_LOW} state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] T_ONE = TIMEOUT_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] C_ONE = COUNTER_WIDTH'(1);

  state_t                   state_q, state_n;
  logic [1:0]               mode_q, mode_n;
  logic                     trig_prev;
  logic [TIMEOUT_WIDTH-1:0] tcnt_q;
  logic                     veto;
  logic                     trig_edge, arm, accept, vetoed, tmo_hit;
  logic                     acc_n, err_set, busy_n, rx_n;

`ifdef TLU_HANDSHAKE_VETO_EN
  assign veto = VETO;
`else
  assign veto = 1'b0;
`endif

  assign trig_edge = TLU_TRIGGER & ~trig_prev;
  // an edge that would be taken if not vetoed; mode 3 never arms
  assign arm       = (state_q == IDLE) & trig_edge & TRIGGER_ENABLE & (TRIGGER_MODE != 2'd3);
  assign accept    = arm & ~veto;
  assign vetoed    = arm & veto;
  assign tmo_hit   = (TIMEOUT_CYCLES != '0) && (tcnt_q == TIMEOUT_CYCLES - T_ONE);

  // next-state and next-output decode; outputs are registered from these
  always_comb begin
    state_n = state_q;
    mode_n  = mode_q;
    acc_n   = 1'b0;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mode_n = TRIGGER_MODE;
          if (TRIGGER_MODE == 2'd2) begin
            state_n = REQ_DATA;
          end else begin
            state_n = WAIT_LOW;
            acc_n   = 1'b1;
          end
        end else if (vetoed && TRIGGER_MODE != 2'd0) begin
          // hold BUSY until the TLU drops the vetoed trigger
          mode_n  = TRIGGER_MODE;
          state_n = WAIT_LOW;
        end
      end
      REQ_DATA: state_n = WAIT_DATA;
      WAIT_DATA: begin
        if (TLU_DATA_RECEIVED_FLAG) begin
          state_n = WAIT_LOW;
          acc_n   = 1'b1;
        end else if (tmo_hit) begin
          state_n = IDLE;
          err_set = 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!TLU_TRIGGER) begin
          state_n = IDLE;
        end else if (tmo_hit) begin
          state_n = IDLE;
          err_set = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE) && (mode_n != 2'd0);
    rx_n   = (state_n == REQ_DATA);
  end

  // state, edge register, latched mode and registered handshake outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q               <= IDLE;
      mode_q                <= 2'd0;
      trig_prev             <= 1'b0;
      TLU_BUSY              <= 1'b0;
      TLU_RECEIVE_DATA_FLAG <= 1'b0;
      TRIGGER_ACCEPTED_FLAG <= 1'b0;
    end else begin
      state_q               <= state_n;
      mode_q                <= mode_n;
      trig_prev             <= TLU_TRIGGER;
      TLU_BUSY              <= busy_n;
      TLU_RECEIVE_DATA_FLAG <= rx_n;
      TRIGGER_ACCEPTED_FLAG <= acc_n;
    end
  end

  // timeout counter: restarts on every state change, saturates while waiting
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tcnt_q <= '0;
    end else if (state_n != state_q) begin
      tcnt_q <= '0;
    end else if ((state_q == WAIT_DATA || state_q == WAIT_LOW) && tcnt_q != '1) begin
      tcnt_q <= tcnt_q + T_ONE;
    end
  end

  // trigger counter: wraps naturally, clear has priority over increment
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      TRIGGER_COUNTER <= '0;
    end else if (TRIGGER_COUNTER_RESET) begin
      TRIGGER_COUNTER <= '0;
    end else if (acc_n) begin
      TRIGGER_COUNTER <= TRIGGER_COUNTER + C_ONE;
    end
  end

  // sticky timeout flag: a new set beats a coincident clear
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      TIMEOUT_ERROR <= 1'b0;
    end else if (err_set) begin
      TIMEOUT_ERROR <= 1'b1;
    end else if (TIMEOUT_ERROR_CLEAR) begin
      TIMEOUT_ERROR <= 1'b0;
    end
  end

`ifdef TLU_HANDSHAKE_VETO_EN
  // vetoed-edge counter, saturating, shares the trigger counter clear
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      VETOED_COUNTER <= 16'd0;
    end else if (TRIGGER_COUNTER_RESET) begin
      VETOED_COUNTER <= 16'd0;
    end else if (vetoed && VETOED_COUNTER != 16'hFFFF) begin
      VETOED_COUNTER <= VETOED_COUNTER + 16'd1;
    end
  end
`endif

endmodule
